tick_arbiter: RTL and testbench

TICK_ARBITER -- requirements
Module: tick_arbiter

---
 rtl/tick_arbiter_pkg.sv | 20 ++
 rtl/rr_pick.sv | 24 ++
 rtl/tick_arbiter.sv | 137 +++++++++++++
 tb/tb_tick_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_arbiter_pkg.sv
// rtl/tick_arbiter_pkg.sv - shared FSM encoding and board constants for tick_arbiter
package tick_arbiter_pkg;

    // Board system clock feeding the tick divider, in Hz
    localparam int unsigned CPU_CLOCK = 27_000_000;

    // Arbiter FSM: pick a winner, load its length, count ticks, report completion
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // True whenever the shared counter is owned by a requester
    function automatic logic is_active(input state_t s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin priority search starting at ptr, ascending with wrap
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    // Walk requesters from ptr upward, wrapping to 0; the first set bit wins
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!valid && req[(int'(ptr) + k) % NREQ]) begin
                valid = 1'b1;
                index = IDX_W'((int'(ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/tick_arbiter.sv
// rtl/tick_arbiter.sv - one shared tick-driven delay counter arbitrated round-robin among requesters
module tick_arbiter
    import tick_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CNT_W-1:0] len,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy
);

    localparam int IDX_W = $clog2(NREQ);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] count_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] winner_q;
    logic [IDX_W-1:0] next_ptr;
    logic [NREQ-1:0]  gnt_q;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_index;
    logic             winner_req;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .index (pick_index)
    );

    // The current owner keeps the counter only while it holds its request
    assign winner_req = req[winner_q];

    // Search starts just past the last owner so everyone else goes first next time
    assign next_ptr = (winner_q == IDX_W'(NREQ - 1)) ? '0 : winner_q + 1'b1;

    // FSM state register; reset wins over every other input
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, abort on owner release takes priority over counting
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = winner_req ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                if (!winner_req) begin
                    state_d = ST_IDLE;
                end else if (count_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Winner latch, counter, grant and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            ptr_q    <= '0;
            winner_q <= '0;
            gnt_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        winner_q <= pick_index;
                    end
                end
                ST_LOAD: begin
                    if (winner_req) begin
                        count_q          <= len[int'(winner_q) * CNT_W +: CNT_W];
                        gnt_q            <= '0;
                        gnt_q[winner_q]  <= 1'b1;
                    end else begin
                        ptr_q <= next_ptr;
                    end
                end
                ST_RUN: begin
                    if (!winner_req) begin
                        gnt_q <= '0;
                        ptr_q <= next_ptr;
                    end else if (count_q != '0 && tick) begin
                        count_q <= count_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    gnt_q <= '0;
                    ptr_q <= next_ptr;
                end
                default: begin
                    gnt_q <= '0;
                end
            endcase
        end
    end

    // Completion pulse lasts exactly the single DONE cycle
    always_comb begin
        done = '0;
        if (state_q == ST_DONE) begin
            done[winner_q] = 1'b1;
        end
    end

    assign gnt  = gnt_q;
    assign busy = is_active(state_q);

endmodule

// File: tb/tb_tick_arbiter.sv
// tb/tb_tick_arbiter.sv - scoreboard bench for tick_arbiter
module tb_tick_arbiter;

    localparam int NREQ  = 4;
    localparam int CNT_W = 32;

    typedef struct {
        int idx;
        int cyc;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  tick = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*CNT_W-1:0] len = '0;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    tick_arbiter #(
        .NREQ  (NREQ),
        .CNT_W (CNT_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .req  (req),
        .len  (len),
        .gnt  (gnt),
        .done (done),
        .busy (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every done pulse must match the next expected completion, index and cycle
    always @(negedge clk) begin
        if (!rst && done !== '0) begin
            exp_t        e;
            logic [3:0]  oh;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done: done=%b at cycle %0d, none expected", done, cyc);
            end else begin
                e  = exp_q.pop_front();
                oh = 4'b0001 << e.idx;
                if (done !== oh || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL done_event: got done=%b at cycle %0d, expected %b at cycle %0d",
                             done, cyc, oh, e.cyc);
                end
            end
        end
    end

    task automatic set_len(input int i, input int v);
        len[i*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    task automatic expect_done(input int idx, input int at);
        exp_t e;
        e.idx = idx;
        e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        tick = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (gnt !== 4'b0000) begin
            failures++;
            $display("FAIL reset_gnt: got %b expected 0000", gnt);
        end
        checks++;
        if (done !== 4'b0000) begin
            failures++;
            $display("FAIL reset_done: got %b expected 0000", done);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_single();
        int n;
        tick = 1'b1;
        set_len(1, 3);
        req = 4'b0010;
        n = cyc;
        expect_done(1, n + 6);
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_load: gnt=%b busy=%b expected gnt=0000 busy=1", gnt, busy);
        end
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010) begin
            failures++;
            $display("FAIL single_gnt: got %b expected 0010", gnt);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (gnt !== 4'b0010) begin
            failures++;
            $display("FAIL single_gnt_done_cycle: got %b expected 0010", gnt);
        end
        req = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || gnt !== 4'b0000) begin
            failures++;
            $display("FAIL single_idle: busy=%b gnt=%b expected busy=0 gnt=0000", busy, gnt);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL single_drain: %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_zero_len();
        int n;
        set_len(0, 0);
        req = 4'b0001;
        n = cyc;
        expect_done(0, n + 3);
        repeat (3) @(negedge clk);
        req = '0;
        @(negedge clk);
        checks++;
        if (done !== 4'b0000 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL zero_len: done=%b pending=%0d expected done=0000 pending=0", done, exp_q.size());
        end
    endtask

    task automatic test_fairness();
        int n;
        int order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        tick = 1'b1;
        for (int i = 0; i < NREQ; i++) set_len(i, 1);
        req = 4'b1111;
        n = cyc;
        for (int k = 0; k < 5; k++) expect_done(order[k], n + 4 + 5 * k);
        repeat (24) @(negedge clk);
        req = '0;
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL fairness_drain: %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_abort();
        int n;
        int m;
        tick = 1'b1;
        set_len(2, 100);
        req = 4'b0100;
        n = cyc;
        repeat (7) @(negedge clk);
        checks++;
        if (gnt !== 4'b0100) begin
            failures++;
            $display("FAIL abort_gnt_run: got %b expected 0100", gnt);
        end
        repeat (5) @(negedge clk);
        req = '0;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_release: gnt=%b busy=%b expected gnt=0000 busy=0", gnt, busy);
        end
        set_len(2, 0);
        set_len(3, 0);
        req = 4'b1100;
        m = cyc;
        expect_done(3, m + 3);
        expect_done(2, m + 7);
        repeat (2) @(negedge clk);
        checks++;
        if (gnt !== 4'b1000) begin
            failures++;
            $display("FAIL abort_next_grant: got %b expected 1000", gnt);
        end
        repeat (5) @(negedge clk);
        req = '0;
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL abort_drain: %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_sparse_tick();
        int n;
        tick = 1'b0;
        set_len(1, 2);
        req = 4'b0010;
        n = cyc;
        expect_done(1, n + 13);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            tick = (k % 5 == 1);
            if (k == 3) set_len(1, 50);
            if (k == 11) begin
                checks++;
                if (gnt !== 4'b0010) begin
                    failures++;
                    $display("FAIL sparse_gnt: got %b expected 0010", gnt);
                end
            end
            if (k == 13) begin
                req = '0;
                tick = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL sparse_end: busy=%b pending=%0d expected busy=0 pending=0", busy, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_run();
        int m;
        tick = 1'b1;
        set_len(0, 20);
        req = 4'b0001;
        repeat (17) @(negedge clk);
        checks++;
        if (gnt !== 4'b0001 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midrun_before: gnt=%b busy=%b expected gnt=0001 busy=1", gnt, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (gnt !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset: gnt=%b done=%b busy=%b expected all 0", gnt, done, busy);
        end
        set_len(1, 0);
        set_len(3, 0);
        req = 4'b1010;
        m = cyc;
        expect_done(1, m + 3);
        repeat (2) @(negedge clk);
        checks++;
        if (gnt !== 4'b0010) begin
            failures++;
            $display("FAIL midrun_ptr_zero: got %b expected 0010", gnt);
        end
        @(negedge clk);
        req = '0;
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL midrun_drain: %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_len();
        test_fairness();
        test_abort();
        test_sparse_tick();
        test_reset_mid_run();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
